// File: rtl/one_shot_scheduler_if.sv
// Purpose: bundles the requester side and the shared one_shot core side of the scheduler.
// Latency: none, wires only.
// Backpressure: requesters hold req high until their done pulse; there is no other flow control.
// Ports (signals): req/len from requesters, gnt/busy/done/err back to them,
//   os_data/os_load/os_trig to the shared core, os_out from the core.
//   master = surrounding logic (requesters + core), slave = the scheduler.
interface one_shot_scheduler_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [N-1:0]   done;
  logic           err;
  logic [W-1:0]   os_data;
  logic           os_load;
  logic           os_trig;
  logic           os_out;

  modport master (
    output req, len, os_out,
    input  gnt, busy, done, err, os_data, os_load, os_trig
  );

  modport slave (
    input  req, len, os_out,
    output gnt, busy, done, err, os_data, os_load, os_trig
  );
endinterface

// File: rtl/one_shot_scheduler.sv
// Purpose: round-robin sharing of one one_shot pulse core among N requesters; load, trigger, watch, report.
// Latency: req before edge k -> gnt/os_load at k+1, os_trig at k+2; done one cycle after os_out falls.
// Backpressure: one job at a time; other requesters wait with req held until granted.
// Ports: clk, rst (async, active-high); bus (one_shot_scheduler_if.slave):
//   req[N], len[N*W] in; gnt[N], busy, done[N], err out; os_data[W], os_load, os_trig out; os_out in.
// Optional: define ONE_SHOT_SCHED_GUARD_EN to insert GUARD idle cycles after every job.
module one_shot_scheduler #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int START_TMO = 4,
  parameter int GUARD     = 2
) (
  input logic                  clk,
  input logic                  rst,
  one_shot_scheduler_if.slave  bus
);
  localparam int PW     = (N > 1) ? $clog2(N) : 1;
  localparam int TW     = W + 3;
  localparam int LO_TMO = (1 << W) + 4;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TRIG, S_WAIT_HI, S_WAIT_LO, S_DONE, S_DONE_ERR, S_GUARD
  } state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  cur;
  logic [TW-1:0]  tmr;
  logic [TW-1:0]  tmr_inc;
  logic [N-1:0]   gnt_q;
  logic [N-1:0]   done_q;
  logic           busy_q;
  logic           err_q;
  logic [W-1:0]   os_data_q;
  logic           os_load_q;
  logic           os_trig_q;

  logic           pick_vld;
  logic [PW-1:0]  pick_idx;
  logic [PW:0]    cand;
  logic [PW-1:0]  ptr_next;

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;
  assign bus.os_data = os_data_q;
  assign bus.os_load = os_load_q;
  assign bus.os_trig = os_trig_q;

  // Timers never actually wrap, but saturating keeps a stuck core from aliasing a timeout.
  assign tmr_inc  = (&tmr) ? tmr : tmr + 1'b1;
  assign ptr_next = (cur == PW'(N - 1)) ? '0 : cur + 1'b1;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!pick_vld && bus.req[cand[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cur       <= '0;
      tmr       <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      os_data_q <= '0;
      os_load_q <= 1'b0;
      os_trig_q <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      os_load_q <= 1'b0;
      os_trig_q <= 1'b0;
      done_q    <= '0;
      err_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            cur       <= pick_idx;
            gnt_q     <= ONE << pick_idx;
            os_data_q <= bus.len[pick_idx*W +: W];
            os_load_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          os_trig_q <= 1'b1;
          state     <= S_TRIG;
        end
        S_TRIG: begin
          tmr   <= '0;
          state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          // os_out already high during TRIG is caught on the first WAIT_HI edge.
          if (bus.os_out) begin
            tmr   <= '0;
            state <= S_WAIT_LO;
          end else if (tmr == TW'(START_TMO - 1)) begin
            err_q <= 1'b1;
            gnt_q <= '0;
            state <= S_DONE_ERR;
          end else begin
            tmr <= tmr_inc;
          end
        end
        S_WAIT_LO: begin
          if (!bus.os_out) begin
            done_q <= ONE << cur;
            state  <= S_DONE;
          end else if (tmr == TW'(LO_TMO - 1)) begin
            err_q <= 1'b1;
            gnt_q <= '0;
            state <= S_DONE_ERR;
          end else begin
            tmr <= tmr_inc;
          end
        end
        S_DONE, S_DONE_ERR: begin
          gnt_q <= '0;
          ptr   <= ptr_next;
          tmr   <= '0;
`ifdef ONE_SHOT_SCHED_GUARD_EN
          state <= S_GUARD;
`else
          busy_q <= 1'b0;
          state  <= S_IDLE;
`endif
        end
`ifdef ONE_SHOT_SCHED_GUARD_EN
        S_GUARD: begin
          // Quiet period for the core: busy stays high, nothing is arbitrated.
          if (tmr == TW'(GUARD - 1)) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            tmr <= tmr_inc;
          end
        end
`endif
        default: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule
